// File: rtl/ysyx_23060061_ifu_pkg.sv
// ysyx_23060061_ifu_pkg
//  Shared definitions for the instruction fetch unit: FSM state encoding,
//  the nop instruction, the default reset PC and the next-state function.
//  No ports (package).
//  Optional feature macro used by the IFU: YSYX_23060061_IFU_MISALIGN_CHECK_EN
package ysyx_23060061_ifu_pkg;

  localparam logic [31:0] IFU_NOP          = 32'h0000_0013;
  localparam logic [31:0] IFU_DEFAULT_PC   = 32'h8000_0000;
  localparam int          IFU_STATE_W      = 3;

  typedef enum logic [IFU_STATE_W-1:0] {
    IFU_RST   = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_EXEC  = 3'd4,
    IFU_FAULT = 3'd5
  } ifu_state_e;

  // Keyed next-state selection on the current state. Any unknown key falls
  // back to RST so a corrupted state register recovers through a refetch.
  function automatic ifu_state_e ifuNextState(
    input ifu_state_e state,
    input logic       reqFire,
    input logic       rspValid,
    input logic       instFire,
    input logic       pcUpdValid,
    input logic       misaligned
  );
    ifu_state_e nextState;
    nextState = IFU_RST;
    case (state)
      IFU_RST:   nextState = IFU_REQ;
      IFU_REQ:   nextState = reqFire  ? IFU_WAIT : IFU_REQ;
      IFU_WAIT:  nextState = rspValid ? IFU_HOLD : IFU_WAIT;
      IFU_HOLD:  nextState = instFire ? IFU_EXEC : IFU_HOLD;
      IFU_EXEC:  nextState = pcUpdValid ? (misaligned ? IFU_FAULT : IFU_REQ) : IFU_EXEC;
      IFU_FAULT: nextState = IFU_FAULT;
      default:   nextState = IFU_RST;
    endcase
    return nextState;
  endfunction

endpackage

// File: rtl/ysyx_23060061_ifu_reg.sv
// ysyx_23060061_ifu_reg
//  Generic enable-gated register with asynchronous active-low reset.
//  Ports:
//    clk     in  1      rising-edge clock
//    rst_n   in  1      asynchronous active-low reset (loads RESET_VAL)
//    i_wen   in  1      write enable
//    i_din   in  WIDTH  next value
//    o_dout  out WIDTH  registered value
module ysyx_23060061_ifu_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dout <= RESET_VAL;
    end else if (i_wen) begin
      o_dout <= i_din;
    end
  end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// ysyx_23060061_ifu
//  Non-speculative instruction fetch unit with a single outstanding fetch.
//  Owns the PC, requests one 32-bit instruction from imem, holds it for the
//  decoder/EXU behind a valid/ready handshake, then waits for the EXU to
//  return the next PC before fetching again. Only XLEN=32 is supported.
//  Config macro: YSYX_23060061_IFU_MISALIGN_CHECK_EN
//    defined   - a misaligned next PC enters a sticky FAULT state (fault=1)
//    undefined - the next PC is silently aligned down; fault tied to 0
//  Ports:
//    clk, rst_n                      clock, async active-low reset
//    imem_req_valid/ready/addr       fetch request channel (addr = pc)
//    imem_rsp_valid/data             fetch response (no backpressure)
//    inst_valid/ready, inst, inst_pc held instruction to the decoder
//    pc_upd_valid, pc_upd            next PC from the EXU (1-cycle pulse)
//    fault                           misaligned-fetch fault
module ysyx_23060061_ifu
  import ysyx_23060061_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = IFU_DEFAULT_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            pc_upd_valid,
  input  logic [XLEN-1:0] pc_upd,
  output logic            fault
);

  logic [IFU_STATE_W-1:0] w_stateQ;
  ifu_state_e             w_state;
  ifu_state_e             w_stateNext;
  logic [XLEN-1:0]        w_pc;
  logic [XLEN-1:0]        w_pcNext;
  logic                   w_pcWen;
  logic                   w_instWen;
  logic                   w_reqFire;
  logic                   w_instFire;
  logic                   w_misaligned;

  assign w_state    = ifu_state_e'(w_stateQ);
  assign w_reqFire  = (w_state == IFU_REQ)  && imem_req_ready;
  assign w_instFire = (w_state == IFU_HOLD) && inst_ready;
  // Responses are only captured in WAIT, which also drops a stale response
  // that lands right after reset.
  assign w_instWen  = (w_state == IFU_WAIT) && imem_rsp_valid;

`ifdef YSYX_23060061_IFU_MISALIGN_CHECK_EN
  assign w_misaligned = |pc_upd[1:0];
  assign w_pcNext     = pc_upd;
  assign w_pcWen      = (w_state == IFU_EXEC) && pc_upd_valid && !w_misaligned;
  assign fault        = (w_state == IFU_FAULT);
`else
  logic w_unusedPcLow;
  assign w_unusedPcLow = ^pc_upd[1:0];
  assign w_misaligned  = 1'b0;
  // Low bits are dropped so a misaligned target fetches its containing word.
  assign w_pcNext      = {pc_upd[XLEN-1:2], 2'b00};
  assign w_pcWen       = (w_state == IFU_EXEC) && pc_upd_valid;
  assign fault         = 1'b0;
`endif

  assign w_stateNext = ifuNextState(w_state, w_reqFire, imem_rsp_valid,
                                    w_instFire, pc_upd_valid, w_misaligned);

  ysyx_23060061_ifu_reg #(.WIDTH(IFU_STATE_W), .RESET_VAL(IFU_RST)) u_stateReg (
    .clk(clk), .rst_n(rst_n), .i_wen(1'b1), .i_din(w_stateNext), .o_dout(w_stateQ)
  );

  ysyx_23060061_ifu_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pcReg (
    .clk(clk), .rst_n(rst_n), .i_wen(w_pcWen), .i_din(w_pcNext), .o_dout(w_pc)
  );

  ysyx_23060061_ifu_reg #(.WIDTH(32), .RESET_VAL(IFU_NOP)) u_instReg (
    .clk(clk), .rst_n(rst_n), .i_wen(w_instWen), .i_din(imem_rsp_data), .o_dout(inst)
  );

  ysyx_23060061_ifu_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_instPcReg (
    .clk(clk), .rst_n(rst_n), .i_wen(w_instWen), .i_din(w_pc), .o_dout(inst_pc)
  );

  // Valids decode straight from the state register, so reset clears them
  // asynchronously and they never glitch on input changes.
  assign imem_req_valid = (w_state == IFU_REQ);
  assign imem_req_addr  = w_pc;
  assign inst_valid     = (w_state == IFU_HOLD);

`ifndef SYNTHESIS
  // A next-PC pulse outside EXEC is dropped by the FSM; flag it in simulation.
  assert property (@(posedge clk) disable iff (!rst_n)
                   pc_upd_valid |-> (w_state == IFU_EXEC))
    else $warning("pc_upd_valid ignored outside EXEC");
`endif

endmodule
